// File: rtl/controller_pkg.sv
// Shared definitions for the controller MMIO register block.
// Contents:
//   fetch_state_t   - fetch sequencer states (IDLE/START/SETTLE/CAPTURE)
//   OFF_*           - per-controller register offsets inside a 4-byte window
//   STAT_*          - bit positions inside the status register
//   status_addr()   - address of the status register for a given controller count
package controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_SETTLE,
    ST_CAPTURE
  } fetch_state_t;

  localparam int OFF_CUR      = 0;
  localparam int OFF_PRESSED  = 1;
  localparam int OFF_RELEASED = 2;

  localparam int STAT_NEW     = 0;
  localparam int STAT_OVERRUN = 1;
  localparam int STAT_BUSY    = 2;

  // The status register sits directly after the last controller window.
  function automatic int status_addr(input int num_controllers);
    return 4 * num_controllers;
  endfunction

endpackage

// File: rtl/controller_event_reg.sv
// Per-controller snapshot and edge-event registers.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   capture       - one-cycle snapshot strobe from the fetch sequencer
//   data          - button byte from the interface (active-high pressed)
//   clr_pressed   - read-to-clear of the pressed register this cycle
//   clr_released  - read-to-clear of the released register this cycle
//   cur           - last snapshot
//   pressed       - sticky rising-edge events since last read
//   released      - sticky falling-edge events since last read
module controller_event_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       capture,
  input  logic [7:0] data,
  input  logic       clr_pressed,
  input  logic       clr_released,
  output logic [7:0] cur,
  output logic [7:0] pressed,
  output logic [7:0] released
);

  logic [7:0] new_pressed;
  logic [7:0] new_released;

  // Edges are taken against the previous snapshot, before cur is overwritten.
  assign new_pressed  = capture ? (data & ~cur) : 8'h00;
  assign new_released = capture ? (~data & cur) : 8'h00;

  // A clear removes only the bits the reader saw; edges from a capture on
  // the same edge survive so no event is ever lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur      <= 8'h00;
      pressed  <= 8'h00;
      released <= 8'h00;
    end else begin
      if (capture) begin
        cur <= data;
      end
      pressed  <= (clr_pressed  ? 8'h00 : pressed)  | new_pressed;
      released <= (clr_released ? 8'h00 : released) | new_released;
    end
  end

endmodule

// File: rtl/controller_mmio.sv
// CPU-facing register block for the serial controller interface.
// Once per frame (vblank_i) it pulses start_fetch_o, waits a fixed settle
// time for the interface to shift in the buttons, then snapshots each
// controller and accumulates pressed/released events.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   vblank_i       - one-cycle frame-start pulse
//   start_fetch_o  - one-cycle fetch request to the controller interface
//   data_LIST_i    - button bytes, controller c at [8c+7:8c]
//   rd_i, addr_i   - CPU read strobe and register address
//   rdata_o        - registered read data, valid the cycle after rd_i
module controller_mmio
  import controller_pkg::*;
#(
  parameter int NUM_CONTROLLERS = 2,
  parameter int ADDR_W          = 4,
  parameter int SETTLE_CYCLES   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         vblank_i,
  output logic                         start_fetch_o,
  input  logic [8*NUM_CONTROLLERS-1:0] data_LIST_i,
  input  logic                         rd_i,
  input  logic [ADDR_W-1:0]            addr_i,
  output logic [7:0]                   rdata_o
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES);
  localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(status_addr(NUM_CONTROLLERS));

  fetch_state_t state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic capture;

  logic [8*NUM_CONTROLLERS-1:0] cur_all, pressed_all, released_all;
  logic [NUM_CONTROLLERS-1:0]   clr_pressed, clr_released;

  logic       new_flag, overrun_flag;
  logic       status_rd, drop;
  logic [7:0] status_val, rd_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // The counter is only loaded in START and reaches zero before CAPTURE,
  // so it rests at zero in IDLE without any explicit saturation logic.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    start_fetch_o = 1'b0;
    capture       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (vblank_i) state_next = ST_START;
      end
      ST_START: begin
        start_fetch_o = 1'b1;
        cnt_next      = CNT_W'(SETTLE_CYCLES - 1);
        state_next    = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt == '0) state_next = ST_CAPTURE;
        else           cnt_next   = cnt - 1'b1;
      end
      ST_CAPTURE: begin
        capture    = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  for (genvar g = 0; g < NUM_CONTROLLERS; g++) begin : g_ctrl
    controller_event_reg u_event (
      .clk          (clk),
      .rst          (rst),
      .capture      (capture),
      .data         (data_LIST_i[8*g +: 8]),
      .clr_pressed  (clr_pressed[g]),
      .clr_released (clr_released[g]),
      .cur          (cur_all[8*g +: 8]),
      .pressed      (pressed_all[8*g +: 8]),
      .released     (released_all[8*g +: 8])
    );
  end

  // A frame start arriving while a fetch is in flight is dropped, not queued.
  assign drop      = vblank_i && (state != ST_IDLE);
  assign status_rd = rd_i && (addr_i == STATUS_ADDR);

  // Set wins over read-to-clear: the reader gets the old value while the
  // event raised on the same edge stays visible for the next read.
  always_ff @(posedge clk) begin
    if (rst) begin
      new_flag     <= 1'b0;
      overrun_flag <= 1'b0;
    end else begin
      new_flag     <= capture | (new_flag & ~status_rd);
      overrun_flag <= drop    | (overrun_flag & ~status_rd);
    end
  end

  // Address decode, read mux and per-register clear strobes.
  always_comb begin
    status_val               = 8'h00;
    status_val[STAT_NEW]     = new_flag;
    status_val[STAT_OVERRUN] = overrun_flag;
    status_val[STAT_BUSY]    = (state != ST_IDLE);

    rd_val       = 8'h00;
    clr_pressed  = '0;
    clr_released = '0;
    for (int c = 0; c < NUM_CONTROLLERS; c++) begin
      if (addr_i == ADDR_W'(4*c + OFF_CUR))      rd_val = cur_all[8*c +: 8];
      if (addr_i == ADDR_W'(4*c + OFF_PRESSED))  rd_val = pressed_all[8*c +: 8];
      if (addr_i == ADDR_W'(4*c + OFF_RELEASED)) rd_val = released_all[8*c +: 8];
      clr_pressed[c]  = rd_i && (addr_i == ADDR_W'(4*c + OFF_PRESSED));
      clr_released[c] = rd_i && (addr_i == ADDR_W'(4*c + OFF_RELEASED));
    end
    if (addr_i == STATUS_ADDR) rd_val = status_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_o <= 8'h00;
    end else if (rd_i) begin
      rdata_o <= rd_val;
    end
  end

endmodule

// File: tb/tb_controller_mmio.sv
// Self-checking bench for controller_mmio. A time-based reference model
// (fetch accepted at edge n, snapshot at edge n+SETTLE+2) predicts every
// output; directed frame sequences are followed by randomized traffic.
module tb_controller_mmio;

  localparam int N      = 2;
  localparam int SETTLE = 16;

  logic        clk;
  logic        rst;
  logic        vblank;
  logic        startFetch;
  logic [15:0] dataIn;
  logic        rdEn;
  logic [3:0]  addrIn;
  logic [7:0]  rdata;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] mCur[N];
  logic [7:0] mPressed[N];
  logic [7:0] mReleased[N];
  logic       mNew, mOverrun, pending;
  logic [7:0] expRdata;
  int         acceptEdge;
  int         edgeNum = 0;

  controller_mmio #(
    .NUM_CONTROLLERS (N),
    .ADDR_W          (4),
    .SETTLE_CYCLES   (SETTLE)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .vblank_i      (vblank),
    .start_fetch_o (startFetch),
    .data_LIST_i   (dataIn),
    .rd_i          (rdEn),
    .addr_i        (addrIn),
    .rdata_o       (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at edge %0d: got 0x%02h expected 0x%02h", tag, edgeNum, got, exp);
    end
  endtask

  task automatic modelClear();
    for (int k = 0; k < N; k++) begin
      mCur[k] = 8'h00; mPressed[k] = 8'h00; mReleased[k] = 8'h00;
    end
    mNew = 1'b0; mOverrun = 1'b0; pending = 1'b0;
    expRdata = 8'h00; acceptEdge = -100;
  endtask

  task automatic doReset();
    rst = 1'b1; vblank = 1'b0; rdEn = 1'b0;
    edgeNum++;
    modelClear();
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("reset_rdata", rdata, 8'h00);
    checkOutput("reset_start", {7'b0, startFetch}, 8'h00);
  endtask

  // Drive one cycle of inputs, advance the model over the same edge, check.
  task automatic applyStimulus(input logic vb, input logic rd, input logic [3:0] a);
    logic [7:0] rv;
    logic [7:0] d;
    logic       busyNow, cap;
    int         c, off;
    vblank = vb; rdEn = rd; addrIn = a;
    edgeNum++;
    busyNow = pending && (edgeNum > acceptEdge);
    cap     = pending && (edgeNum == acceptEdge + SETTLE + 2);
    c   = int'(a) / 4;
    off = int'(a) % 4;
    rv  = 8'h00;
    if (int'(a) < 4*N) begin
      if (off == 0) rv = mCur[c];
      else if (off == 1) rv = mPressed[c];
      else if (off == 2) rv = mReleased[c];
    end else if (int'(a) == 4*N) begin
      rv = {5'b0, busyNow, mOverrun, mNew};
    end
    if (rd) begin
      expRdata = rv;
      if (int'(a) < 4*N && off == 1) mPressed[c] = 8'h00;
      if (int'(a) < 4*N && off == 2) mReleased[c] = 8'h00;
      if (int'(a) == 4*N) begin mNew = 1'b0; mOverrun = 1'b0; end
    end
    if (cap) begin
      for (int k = 0; k < N; k++) begin
        d = dataIn[8*k +: 8];
        mPressed[k]  = mPressed[k]  | (d & ~mCur[k]);
        mReleased[k] = mReleased[k] | (~d & mCur[k]);
        mCur[k] = d;
      end
      mNew = 1'b1;
      pending = 1'b0;
    end
    if (vb) begin
      if (busyNow) mOverrun = 1'b1;
      else begin pending = 1'b1; acceptEdge = edgeNum; end
    end
    @(posedge clk); #1;
    checkOutput("start_fetch", {7'b0, startFetch}, {7'b0, (pending && acceptEdge == edgeNum)});
    checkOutput(rd ? $sformatf("read_addr%0d", a) : "rdata_hold", rdata, expRdata);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) applyStimulus(1'b0, 1'b0, 4'd0);
  endtask

  task automatic readReg(input logic [3:0] a);
    applyStimulus(1'b0, 1'b1, a);
  endtask

  // Full frame: vblank, then enough cycles to pass the snapshot edge.
  task automatic frame(input logic [15:0] d);
    dataIn = d;
    applyStimulus(1'b1, 1'b0, 4'd0);
    idle(SETTLE + 2);
  endtask

  initial begin
    rst = 1'b0; vblank = 1'b0; rdEn = 1'b0; addrIn = 4'd0; dataIn = 16'h0000;
    modelClear();
    @(posedge clk); #1;
    doReset();
    for (int a = 0; a < 16; a++) readReg(4'(a));

    // First fetch: start pulse, busy during settle, new flag read-to-clear
    dataIn = 16'h0000;
    applyStimulus(1'b1, 1'b0, 4'd0);
    idle(5);
    readReg(4'd8);
    idle(SETTLE + 2 - 6);
    readReg(4'd8);
    readReg(4'd8);

    // 0x00 -> 0x81 -> 0x01 on controller 0
    frame(16'h0081);
    readReg(4'd0); readReg(4'd1); readReg(4'd1);
    frame(16'h0001);
    readReg(4'd2);

    // Two frames without reads accumulate events
    frame(16'h000F);
    frame(16'h00F0);
    readReg(4'd1); readReg(4'd2); readReg(4'd8);

    // Overrun: second vblank mid-settle is dropped
    applyStimulus(1'b1, 1'b0, 4'd0);
    idle(6);
    applyStimulus(1'b1, 1'b0, 4'd0);
    idle(SETTLE + 2 - 7);
    readReg(4'd8); readReg(4'd8);
    frame(16'h00F0);
    readReg(4'd8);

    // Read of pressed1 on the capture edge
    frame(16'h0000); readReg(4'd5);
    frame(16'h0200);
    dataIn = 16'h4200;
    applyStimulus(1'b1, 1'b0, 4'd0);
    idle(SETTLE + 1);
    readReg(4'd5);
    readReg(4'd5);

    // Vblank on the capture edge is dropped as well
    applyStimulus(1'b1, 1'b0, 4'd0);
    idle(SETTLE + 1);
    applyStimulus(1'b1, 1'b1, 4'd8);
    readReg(4'd8);

    // Reset during settle aborts the fetch
    dataIn = 16'hFFFF;
    applyStimulus(1'b1, 1'b0, 4'd0);
    idle(5);
    doReset();
    idle(SETTLE + 4);
    for (int a = 0; a < 16; a++) readReg(4'(a));
    frame(16'h1234);
    readReg(4'd0); readReg(4'd4);

    // Reserved and unmapped addresses
    readReg(4'd3); readReg(4'd9); readReg(4'd15);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) dataIn = 16'($urandom);
      if ($urandom_range(0, 599) == 0) doReset();
      else applyStimulus($urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0,
                         4'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
